// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, register constants
// and stall-cause codes reused by performance counters.
package pipe_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MD_WAIT  = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_INIT = 3'd1,
        CAUSE_MEM  = 3'd2,
        CAUSE_MD   = 3'd3,
        CAUSE_LU   = 3'd4,
        CAUSE_CTRL = 3'd5
    } stall_cause_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_lu.sv
// Load-use comparator: a load in EX whose destination feeds a source of the ID instruction.
module hazard_detect_lu
    import pipe_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       lu
);

    // $zero is never a real dependency, so a load targeting it cannot cause a stall.
    assign lu = ex_mem_read && (ex_rt != REG_ZERO) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, control flush,
// mul/div occupancy and memory wait, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             ex_md_start,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

    state_t             state_reg, state_next;
    logic [3:0]         md_cnt_reg, md_cnt_next;
    logic [CNT_W-1:0]   stall_cycles_reg;
    stall_cause_t       cause;
    logic               lu;

    hazard_detect_lu u_lu (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .lu          (lu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= INIT;
            md_cnt_reg       <= 4'd0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg  <= state_next;
            md_cnt_reg <= md_cnt_next;
            if ((state_reg != INIT) && !pc_write && (stall_cycles_reg != '1))
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        md_cnt_next  = md_cnt_reg;
        cause        = CAUSE_NONE;
        if_id_freeze = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        md_busy      = 1'b0;

        case (state_reg)
            INIT: begin
                cause        = CAUSE_INIT;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                state_next   = RUN;
            end
            MD_WAIT: begin
                cause        = CAUSE_MD;
                md_busy      = 1'b1;
                if_id_freeze = 1'b1;
                pipe_hold    = 1'b1;
                md_cnt_next  = md_cnt_reg - 4'd1;
                if (md_cnt_reg <= 4'd1)
                    state_next = mem_wait ? MEM_WAIT : RUN;
            end
            default: begin
                // MEM_WAIT re-evaluates the RUN priorities so release costs no extra bubble.
                state_next = RUN;
                if (mem_wait) begin
                    cause        = CAUSE_MEM;
                    if_id_freeze = 1'b1;
                    pipe_hold    = 1'b1;
                    state_next   = MEM_WAIT;
                end else if (ex_md_start) begin
                    cause        = CAUSE_MD;
                    if_id_freeze = 1'b1;
                    pipe_hold    = 1'b1;
                    md_busy      = 1'b1;
                    md_cnt_next  = MD_LOAD;
                    state_next   = MD_WAIT;
                end else if (lu) begin
                    cause        = CAUSE_LU;
                    if_id_freeze = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (id_branch_taken || id_jump) begin
                    cause        = CAUSE_CTRL;
                    if_id_flush  = 1'b1;
                end
            end
        endcase

        pc_write = (cause == CAUSE_NONE) || (cause == CAUSE_CTRL);
    end

    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench: stimulus pushes hand-written expected flags per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int MD_LATENCY = 4;

    // {pc_write, if_id_freeze, if_id_flush, id_ex_bubble, pipe_hold, md_busy}
    localparam logic [5:0] E_INIT = 6'b001100;
    localparam logic [5:0] E_RUN  = 6'b100000;
    localparam logic [5:0] E_LU   = 6'b010100;
    localparam logic [5:0] E_BR   = 6'b101000;
    localparam logic [5:0] E_HOLD = 6'b010010;
    localparam logic [5:0] E_MD   = 6'b010011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic id_uses_rt = 0, ex_mem_read = 0, id_branch_taken = 0, id_jump = 0;
    logic ex_md_start = 0, mem_wait = 0;
    logic pc_write, if_id_freeze, if_id_flush, id_ex_bubble, pipe_hold, md_busy;
    logic [CNT_W-1:0] stall_cycles;

    typedef struct {
        int               idx;
        logic [5:0]       flags;
        logic [CNT_W-1:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int step_no = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_branch_taken(id_branch_taken), .id_jump(id_jump),
        .ex_md_start(ex_md_start), .mem_wait(mem_wait),
        .pc_write(pc_write), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold), .md_busy(md_busy),
        .stall_cycles(stall_cycles)
    );

    // One cycle: apply inputs just after the edge and queue the expected response.
    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic mr, input logic [4:0] ert,
                        input logic br, input logic jmp, input logic md, input logic mw,
                        input logic [5:0] exp_flags);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_mem_read = mr; ex_rt = ert; id_branch_taken = br; id_jump = jmp;
        ex_md_start = md; mem_wait = mw;
        if (!rst) exp_stall = 0;
        e.idx = step_no;
        e.flags = exp_flags;
        e.stall = CNT_W'(exp_stall);
        exp_q.push_back(e);
        step_no++;
        // Cycles outside INIT with the PC held are counted, saturating at all-ones.
        if (!(exp_flags[3] && !exp_flags[5]) && !exp_flags[5] && exp_stall < (1 << CNT_W) - 1)
            exp_stall++;
    endtask

    task automatic idle(input logic [5:0] exp_flags);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp_flags);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] act;
            e = exp_q.pop_front();
            act = {pc_write, if_id_freeze, if_id_flush, id_ex_bubble, pipe_hold, md_busy};
            checks++;
            if (act !== e.flags) begin
                errors++;
                $display("FAIL flags step %0d: got %b expected %b", e.idx, act, e.flags);
            end
            checks++;
            if (stall_cycles !== e.stall) begin
                errors++;
                $display("FAIL stall_cycles step %0d: got %0d expected %0d", e.idx, stall_cycles, e.stall);
            end
            $display("step %0d flags=%b stall=%0d", e.idx, act, stall_cycles);
        end
    end

    initial begin
        // Reset held three cycles, then release; first cycle after release is still INIT.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_INIT);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_INIT);
        idle(E_RUN);

        // Load-use on rs: one-cycle stall, then ex_rt=0 and unused rt give no stall.
        step(1, 8, 0, 0, 1, 8, 0, 0, 0, 0, E_LU);
        idle(E_RUN);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, E_RUN);
        step(1, 0, 9, 0, 1, 9, 0, 0, 0, 0, E_RUN);

        // Branch and jump flush; branch waiting on a load via rt stalls before flushing.
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_BR);
        idle(E_RUN);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR);
        step(1, 0, 7, 1, 1, 7, 1, 0, 0, 0, E_LU);
        step(1, 0, 7, 1, 0, 7, 1, 0, 0, 0, E_BR);
        idle(E_RUN);

        // Mul/div occupies four cycles; a repeated start inside MD_WAIT is ignored.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MD);
        idle(E_MD);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MD);
        idle(E_MD);
        idle(E_RUN);

        // Memory wait arriving in MD_WAIT cycle 2: md ends on time, then MEM_WAIT, then resume.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MD);
        idle(E_MD);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_MD);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_MD);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_HOLD);
        idle(E_RUN);

        // mem_wait outranks a simultaneous mul/div start.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_HOLD);
        idle(E_RUN);

        // Long memory wait drives the 4-bit counter into saturation at 15.
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_HOLD);

        // Reset dropped mid-stall takes effect before the next clock edge.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_INIT);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_INIT);
        idle(E_RUN);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
